// File: rtl/rob_retire.sv
// Reorder buffer: single-issue allocation, two completion ports, in-order dual retirement.
// Retire and free outputs are registered and valid for exactly one cycle per retire.
module rob_retire #(
   parameter int unsigned ROB_DEPTH = 16,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned AR_SIZE   = 6
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               alloc_valid,
   input  logic               alloc_has_dest,
   input  logic [5:0]         alloc_areg,
   input  logic [AR_SIZE-1:0] alloc_preg,
   input  logic [AR_SIZE-1:0] alloc_old_preg,
   output logic               alloc_ready,
   output logic [TAG_W-1:0]   alloc_tag,
   input  logic               cmpl_valid1,
   input  logic [TAG_W-1:0]   cmpl_tag1,
   input  logic [31:0]        cmpl_data1,
   input  logic               cmpl_valid2,
   input  logic [TAG_W-1:0]   cmpl_tag2,
   input  logic [31:0]        cmpl_data2,
   output logic               retire_en,
   output logic [AR_SIZE-1:0] retire_paddr1,
   output logic [AR_SIZE-1:0] retire_paddr2,
   output logic [31:0]        retire_data1,
   output logic [31:0]        retire_data2,
   output logic [5:0]         retire_areg1,
   output logic [5:0]         retire_areg2,
   output logic               free_valid1,
   output logic               free_valid2,
   output logic [AR_SIZE-1:0] free_preg1,
   output logic [AR_SIZE-1:0] free_preg2,
   output logic [TAG_W:0]     rob_count,
   output logic               rob_empty
);

   logic [ROB_DEPTH-1:0] valid_q, done_q, has_dest_q;
   logic [5:0]           areg_q     [ROB_DEPTH];
   logic [AR_SIZE-1:0]   preg_q     [ROB_DEPTH];
   logic [AR_SIZE-1:0]   old_preg_q [ROB_DEPTH];
   logic [31:0]          data_q     [ROB_DEPTH];

   logic [TAG_W-1:0] head_q, tail_q, head1;
   logic [TAG_W:0]   count_q, count_d;
   logic             alloc_fire, slot1, slot2, c1_hit, c2_hit;
   logic [1:0]       retire_num;

   assign head1       = head_q + TAG_W'(1);
   assign alloc_ready = (count_q != (TAG_W+1)'(ROB_DEPTH));
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_tag   = tail_q;
   assign rob_count   = count_q;
   assign rob_empty   = (count_q == '0);

   assign slot1 = valid_q[head_q] && done_q[head_q];
   assign slot2 = slot1 && valid_q[head1] && done_q[head1];

   // Port 1 takes priority when both ports name the same entry.
   assign c1_hit = cmpl_valid1 && valid_q[cmpl_tag1] && !done_q[cmpl_tag1];
   assign c2_hit = cmpl_valid2 && valid_q[cmpl_tag2] && !done_q[cmpl_tag2] &&
                   !(c1_hit && (cmpl_tag1 == cmpl_tag2));

   always_comb begin
      retire_num = 2'd0;
      if (slot2)      retire_num = 2'd2;
      else if (slot1) retire_num = 2'd1;
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_num);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q    <= '0;
         done_q     <= '0;
         has_dest_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         if (slot1) valid_q[head_q] <= 1'b0;
         if (slot2) valid_q[head1]  <= 1'b0;
         if (alloc_fire) begin
            valid_q[tail_q]    <= 1'b1;
            done_q[tail_q]     <= 1'b0;
            has_dest_q[tail_q] <= alloc_has_dest;
            tail_q             <= tail_q + TAG_W'(1);
         end
         if (c1_hit) done_q[cmpl_tag1] <= 1'b1;
         if (c2_hit) done_q[cmpl_tag2] <= 1'b1;
         head_q  <= head_q + TAG_W'(retire_num);
         count_q <= count_d;
      end
   end

   // Payload is only read once the entry is valid and done, so it needs no reset.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         areg_q[tail_q]     <= alloc_areg;
         preg_q[tail_q]     <= alloc_preg;
         old_preg_q[tail_q] <= alloc_old_preg;
      end
      if (c1_hit) data_q[cmpl_tag1] <= cmpl_data1;
      if (c2_hit) data_q[cmpl_tag2] <= cmpl_data2;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         retire_en     <= 1'b0;
         retire_paddr1 <= '0;
         retire_paddr2 <= '0;
         retire_data1  <= '0;
         retire_data2  <= '0;
         retire_areg1  <= '0;
         retire_areg2  <= '0;
         free_valid1   <= 1'b0;
         free_valid2   <= 1'b0;
         free_preg1    <= '0;
         free_preg2    <= '0;
      end else begin
         retire_en     <= slot1;
         retire_paddr1 <= (slot1 && has_dest_q[head_q]) ? preg_q[head_q] : '0;
         retire_paddr2 <= (slot2 && has_dest_q[head1])  ? preg_q[head1]  : '0;
         retire_data1  <= slot1 ? data_q[head_q] : '0;
         retire_data2  <= slot2 ? data_q[head1]  : '0;
         retire_areg1  <= slot1 ? areg_q[head_q] : '0;
         retire_areg2  <= slot2 ? areg_q[head1]  : '0;
         if (slot1 && has_dest_q[head_q] && (old_preg_q[head_q] != '0)) begin
            free_valid1 <= 1'b1;
            free_preg1  <= old_preg_q[head_q];
         end else begin
            free_valid1 <= 1'b0;
            free_preg1  <= '0;
         end
         if (slot2 && has_dest_q[head1] && (old_preg_q[head1] != '0)) begin
            free_valid2 <= 1'b1;
            free_preg2  <= old_preg_q[head1];
         end else begin
            free_valid2 <= 1'b0;
            free_preg2  <= '0;
         end
      end
   end

endmodule
